// File: rtl/sha3_padder_stream.sv
// sha3_padder_stream: packs a byte-oriented message stream into RATE-bit Keccak blocks with multi-rate padding.
// Revision: 1.0
`default_nettype none

module sha3_padder_stream #(
  parameter int         IN_W   = 32,
  parameter int         RATE   = 1088,
  parameter logic [7:0] SUFFIX = 8'h06
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [IN_W-1:0]              in,
  input  logic                         in_valid,
  input  logic                         in_last,
  input  logic [$clog2(IN_W/8)-1:0]    byte_num,
  output logic                         in_ready,
  output logic [RATE-1:0]              out,
  output logic                         out_valid,
  output logic                         out_last,
  input  logic                         f_ack
);

  localparam int BYTES = IN_W / 8;
  localparam int WORDS = RATE / IN_W;
  localparam int CNT_W = $clog2(WORDS + 1);

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    PAD    = 2'd1,
    FULL   = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [RATE-1:0]   block, block_nx;
  logic              valid_nx, last_nx, ready_nx;
  logic              completes;
  logic [IN_W-1:0]   final_word;
  logic [IN_W-1:0]   pad_word;

  assign completes = (cnt == CNT_W'(WORDS - 1));
  assign out       = block;

  // Final word: message bytes, then the domain suffix, then zeros; the
  // closing 0x80 lands in the LSB byte only when this word ends the block.
  always_comb begin
    final_word = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (i < int'(byte_num)) begin
        final_word[IN_W-1-8*i -: 8] = in[IN_W-1-8*i -: 8];
      end else if (i == int'(byte_num)) begin
        final_word[IN_W-1-8*i -: 8] = SUFFIX;
      end
    end
    if (completes) begin
      final_word[7:0] = final_word[7:0] | 8'h80;
    end
  end

  assign pad_word = completes ? {{(IN_W-8){1'b0}}, 8'h80} : '0;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    block_nx = block;
    valid_nx = out_valid;
    last_nx  = out_last;
    ready_nx = in_ready;
    case (state)
      ACCEPT: begin
        ready_nx = 1'b1;
        if (in_valid && in_ready) begin
          block_nx = (block << IN_W) | RATE'(in_last ? final_word : in);
          if (completes) begin
            cnt_nx   = '0;
            valid_nx = 1'b1;
            last_nx  = in_last;
            ready_nx = 1'b0;
            state_nx = FULL;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
            if (in_last) begin
              ready_nx = 1'b0;
              state_nx = PAD;
            end
          end
        end
      end
      PAD: begin
        ready_nx = 1'b0;
        block_nx = (block << IN_W) | RATE'(pad_word);
        if (completes) begin
          cnt_nx   = '0;
          valid_nx = 1'b1;
          last_nx  = 1'b1;
          state_nx = FULL;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      FULL: begin
        ready_nx = 1'b0;
        if (f_ack) begin
          valid_nx = 1'b0;
          last_nx  = 1'b0;
          ready_nx = 1'b1;
          state_nx = ACCEPT;
        end
      end
      default: begin
        state_nx = ACCEPT;
        cnt_nx   = '0;
        valid_nx = 1'b0;
        last_nx  = 1'b0;
        ready_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ACCEPT;
      cnt       <= '0;
      block     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      block     <= block_nx;
      out_valid <= valid_nx;
      out_last  <= last_nx;
      in_ready  <= ready_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sha3_padder_stream.sv
// Directed bench for sha3_padder_stream at IN_W=32, RATE=1088 (34 words per block).
`default_nettype none

module tb_sha3_padder_stream;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   in;
  logic          in_valid;
  logic          in_last;
  logic [1:0]    byte_num;
  logic          in_ready;
  logic [1087:0] out;
  logic          out_valid;
  logic          out_last;
  logic          f_ack;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [31:0]   exp_w [34];

  sha3_padder_stream #(.IN_W(32), .RATE(1088), .SUFFIX(8'h06)) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .in_valid (in_valid),
    .in_last  (in_last),
    .byte_num (byte_num),
    .in_ready (in_ready),
    .out      (out),
    .out_valid(out_valid),
    .out_last (out_last),
    .f_ack    (f_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_block(input string tag);
    for (int k = 0; k < 34; k++)
      chk($sformatf("%s_w%0d", tag, k), 64'(out[1087-32*k -: 32]), 64'(exp_w[k]));
  endtask

  task automatic set_pad_block(input logic [31:0] first);
    for (int k = 0; k < 34; k++) exp_w[k] = 32'h0;
    exp_w[0]  = first;
    exp_w[33] = 32'h0000_0080;
  endtask

  task automatic send(input logic [31:0] w, input logic last, input logic [1:0] bn);
    int t;
    @(negedge clk);
    in = w; in_valid = 1'b1; in_last = last; byte_num = bn;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
  endtask

  task automatic wait_block(input int exp_pad, input string tag);
    int n;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; byte_num = 2'd0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(exp_pad));
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
  endtask

  task automatic do_ack(input string tag);
    @(negedge clk);
    f_ack = 1'b1;
    @(negedge clk);
    f_ack = 1'b0;
    chk({tag, "_ack_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_ack_last"},  64'(out_last),  64'd0);
    chk({tag, "_ack_ready"}, 64'(in_ready),  64'd1);
  endtask

  initial begin
    reset = 1'b0; in = '0; in_valid = 1'b0; in_last = 1'b0; byte_num = '0; f_ack = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last",  64'(out_last),  64'd0);
    chk("rst_out_zero",  64'(|out),      64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Empty message
    send(32'hDEAD_BEEF, 1'b1, 2'd0);
    wait_block(33, "empty");
    chk("empty_last", 64'(out_last), 64'd1);
    set_pad_block(32'h0600_0000);
    chk_block("empty");
    do_ack("empty");

    // "abc"
    send(32'h6162_63AA, 1'b1, 2'd3);
    wait_block(33, "abc");
    chk("abc_last", 64'(out_last), 64'd1);
    set_pad_block(32'h6162_6306);
    chk_block("abc");
    do_ack("abc");

    // Exact fill: final word completes the block, suffix and 0x80 share a byte
    for (int k = 0; k < 33; k++) begin
      exp_w[k] = 32'hA000_0000 + k;
      send(32'hA000_0000 + k, 1'b0, 2'd0);
    end
    send(32'h1122_3344, 1'b1, 2'd3);
    exp_w[33] = 32'h1122_3386;
    wait_block(0, "exact");
    chk("exact_last", 64'(out_last), 64'd1);
    chk_block("exact");
    do_ack("exact");

    // Multi-block: 34 full data words, then an empty final word
    for (int k = 0; k < 34; k++) begin
      exp_w[k] = 32'hC0DE_0000 + (k * 32'h0101);
      send(32'hC0DE_0000 + (k * 32'h0101), 1'b0, 2'd0);
    end
    wait_block(0, "mb1");
    chk("mb1_last", 64'(out_last), 64'd0);
    chk_block("mb1");

    // Backpressure on the held block with a pending final word
    in = 32'h5555_5555; in_valid = 1'b1; in_last = 1'b1; byte_num = 2'd0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_in_ready_c%0d", c),  64'(in_ready),  64'd0);
      chk($sformatf("bp_out_valid_c%0d", c), 64'(out_valid), 64'd1);
      chk_block($sformatf("bp_c%0d", c));
      @(negedge clk);
    end
    f_ack = 1'b1;
    @(negedge clk);
    f_ack = 1'b0;
    chk("bp_after_ack_ready", 64'(in_ready),  64'd1);
    chk("bp_after_ack_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    wait_block(33, "mb2");
    chk("mb2_last", 64'(out_last), 64'd1);
    set_pad_block(32'h0600_0000);
    chk_block("mb2");
    do_ack("mb2");

    // Reset in the middle of padding
    send(32'h6162_63AA, 1'b1, 2'd3);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; byte_num = 2'd0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_last",  64'(out_last),  64'd0);
    chk("midrst_in_ready",  64'(in_ready),  64'd0);
    chk("midrst_out_zero",  64'(|out),      64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_release_ready", 64'(in_ready), 64'd1);
    send(32'h6162_63AA, 1'b1, 2'd3);
    wait_block(33, "abc2");
    chk("abc2_last", 64'(out_last), 64'd1);
    set_pad_block(32'h6162_6306);
    chk_block("abc2");
    do_ack("abc2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/sha3_padder_stream.md
Name: sha3_padder_stream

Overview:
- Sequential, parametrised SHA-3/Keccak message padder.
- Accepts a byte-packed message stream in IN_W-bit words and assembles RATE-bit blocks.
- Applies multi-rate padding: domain suffix after the last message byte, 0x80 OR'd into the last byte of the final block.
- Presents each completed block to the Keccak permutation core through a valid/ack handshake.

Parameters:
- IN_W, 32: input word width in bits; multiple of 8, at least 16.
- RATE, 1088: block (rate) width in bits; multiple of IN_W. 1088 corresponds to SHA3-256.
- SUFFIX, 8'h06: domain-separation byte. Use 8'h06 for SHA3, 8'h1F for SHAKE, 8'h01 for legacy Keccak.

Ports:
- clk  in  1: clock.
- reset  in  1: asynchronous reset, active low.
- in  in  IN_W: message word; first byte in MSBs.
- in_valid  in  1: word present on `in`.
- in_last  in  1: current word is the final word of the message.
- byte_num  in  clog2(IN_W/8): valid bytes in the final word, 0..IN_W/8-1. Ignored unless in_last=1.
- in_ready  out  1: padder accepts a word this cycle.
- out  out  RATE: assembled block; first word in MSBs.
- out_valid  out  1: `out` holds a complete block.
- out_last  out  1: block is the final (padded) block of the message. Qualified by out_valid.
- f_ack  in  1: consumer has taken the block.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_last=0, out=0, word counter=0, state=ACCEPT.
- Reset is asynchronous and may occur mid-message or mid-padding. It discards all partial state.
- First cycle after reset release: in_ready=1.

Message convention:
- Non-final words always carry all IN_W/8 bytes.
- A message whose length is a multiple of IN_W/8 ends with an extra word: in_last=1, byte_num=0.
- The final word therefore always has at least one free byte.

State ACCEPT:
- in_ready = 1 when out_valid=0.
- Transfer occurs when in_valid && in_ready.
- Non-final transfer: buffer <= {buffer[RATE-IN_W-1:0], in}; counter increments.
- Final transfer: shift in a padded word W built as follows:
  - bytes 0..byte_num-1 from `in`;
  - byte byte_num = SUFFIX;
  - remaining bytes = 0;
  - if this word completes the block, OR 0x80 into its last (LSB) byte. With byte_num=IN_W/8-1 this yields SUFFIX|0x80 (0x86 for SHA3).
- If a final transfer leaves the block incomplete, go to PAD.
- Completing transfer (counter reaches RATE/IN_W): the next cycle has out_valid=1, in_ready=0, counter=0, and out_last=1 if the word was final.

State PAD:
- in_ready=0.
- Shift one zero word per cycle.
- The word that completes the block is 0x80 in its LSB byte; all other pad words are 0.
- The cycle after the completing shift: out_valid=1, out_last=1.

State FULL:
- out_valid held; `out` stable.
- f_ack sampled high: the next cycle has out_valid=0 and out_last=0, then return to ACCEPT with in_ready=1.
- If f_ack never arrives, the block is held indefinitely.

Timing and handshake rules:
- Latency: a full-data block is valid 1 cycle after its last word is accepted.
- A padded block is valid 1 + (remaining word slots) cycles after the final word is accepted.
- f_ack while out_valid=0 is ignored.
- in_valid while in_ready=0 is ignored; the word is not consumed.
- Simultaneous f_ack and in_valid in FULL: the word is not taken that cycle.
- Consecutive messages need no idle cycles beyond the handshake.

Test Plan:
- Empty message (IN_W=32, RATE=1088, 34 words): in_last=1, byte_num=0 → 33 PAD cycles, then out_valid=1, out_last=1. out[1087:1056]=0x06000000, middle words 0, out[31:0]=0x00000080.
- "abc": in=0x616263xx, byte_num=3, in_last=1 → out[1087:1056]=0x61626306, out[31:0]=0x00000080, out_last=1.
- Exact fill: 33 full words, then final word 0x11223344 with byte_num=3 → no PAD cycles. out_valid the next cycle; out[31:0]=0x11223386; out_last=1.
- Multi-block: 34 full words, then in_last with byte_num=0.
  - Block 1: out_last=0, holds the 34 data words unchanged.
  - After f_ack, block 2: out[1087:1056]=0x06000000, out[31:0]=0x80, out_last=1.
- Backpressure: hold f_ack=0 for 5 cycles with in_valid=1 → in_ready=0 throughout and `out` stable. After f_ack, the next word is accepted; no word is lost or duplicated.
- Reset mid-PAD: assert reset low during PAD → outputs clear immediately. After release, the "abc" message yields the same block as the "abc" scenario.
